alu_exec_mc: RTL and testbench

- Multi-cycle ALU execution unit; the consumer of the 4-bit ALUop codes from ALUop.vh that the ALU decoder produces.
- Accepts one operation per handshake and returns one registered result per handshake.
- Shifts run bit-serially, one bit per cycle; all other ops complete in one cycle.
- Sits in the execute stage as the area-reduced alternative to the combinational ALU; the pipeline stalls on in_ready/out_valid.

---
 rtl/alu_exec_mc.sv | 146 ++++++++++++++
 tb/tb_alu_exec_mc.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_mc.sv
// Multi-cycle ALU execution unit: single-cycle logic ops, bit-serial shifts, and a
// valid/ready handshake on both the operation input and the result output.
module alu_exec_mc #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUop,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_AND    = 4'd2;
  localparam logic [3:0] ALU_OR     = 4'd3;
  localparam logic [3:0] ALU_XOR    = 4'd4;
  localparam logic [3:0] ALU_SLT    = 4'd5;
  localparam logic [3:0] ALU_SLTU   = 4'd6;
  localparam logic [3:0] ALU_SLL    = 4'd7;
  localparam logic [3:0] ALU_SRL    = 4'd8;
  localparam logic [3:0] ALU_SRA    = 4'd9;
  localparam logic [3:0] ALU_COPY_A = 4'd10;
  localparam logic [3:0] ALU_COPY_B = 4'd11;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [3:0]         op_q, op_d;

  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH-1:0]   a_sh1;
  logic [WIDTH-1:0]   acc_sh1;
  logic               is_shift;

  function automatic logic [WIDTH-1:0] shift1(input logic [3:0] op, input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = v;
    if (op == ALU_SLL) begin
      r = v << 1;
    end else if (op == ALU_SRL) begin
      r = v >> 1;
    end else if (op == ALU_SRA) begin
      r = {v[WIDTH-1], v[WIDTH-1:1]};
    end
    return r;
  endfunction

  assign shamt    = B[SHAMT_W-1:0];
  assign is_shift = (ALUop == ALU_SLL) || (ALUop == ALU_SRL) || (ALUop == ALU_SRA);
  assign a_sh1    = shift1(ALUop, A);
  assign acc_sh1  = shift1(op_q, acc_q);

  always_comb begin
    alu_res = '0;
    case (ALUop)
      ALU_ADD:    alu_res = A + B;
      ALU_SUB:    alu_res = A - B;
      ALU_AND:    alu_res = A & B;
      ALU_OR:     alu_res = A | B;
      ALU_XOR:    alu_res = A ^ B;
      ALU_SLT:    alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      ALU_SLTU:   alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
      ALU_COPY_A: alu_res = A;
      ALU_COPY_B: alu_res = B;
      default:    alu_res = '0;
    endcase
  end

  // The first shift step is taken on the accept edge, so accept-to-out_valid equals shamt.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (!is_shift) begin
            result_d = alu_res;
            state_d  = StDone;
          end else if (shamt == '0) begin
            result_d = A;
            state_d  = StDone;
          end else if (shamt == SHAMT_W'(1)) begin
            result_d = a_sh1;
            state_d  = StDone;
          end else begin
            acc_d   = a_sh1;
            cnt_d   = shamt - SHAMT_W'(1);
            op_d    = ALUop;
            state_d = StShift;
          end
        end
      end
      StShift: begin
        acc_d = acc_sh1;
        cnt_d = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          result_d = acc_sh1;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign result    = result_q;

endmodule

// File: tb/tb_alu_exec_mc.sv
// Directed bench for alu_exec_mc: handshake timing, op results, serial shift latency,
// backpressure and reset behaviour.
module tb_alu_exec_mc;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_XOR    = 4'd4;
  localparam logic [3:0] ALU_SLT    = 4'd5;
  localparam logic [3:0] ALU_SLTU   = 4'd6;
  localparam logic [3:0] ALU_SLL    = 4'd7;
  localparam logic [3:0] ALU_SRL    = 4'd8;
  localparam logic [3:0] ALU_SRA    = 4'd9;
  localparam logic [3:0] ALU_COPY_B = 4'd11;
  localparam logic [3:0] ALU_XXX    = 4'd15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  ALUop = 4'd0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        busy;

  int checks = 0;
  int errors = 0;

  alu_exec_mc #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ALUop     (ALUop),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Accepts one op, scrambles the inputs after the accept edge, and waits (bounded) for
  // out_valid. lat counts the accept edge as cycle 1.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit handshake, output int lat, output logic [31:0] res,
                        output bit busy_all);
    @(negedge clk);
    ALUop = op; A = a; B = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; A = ~a; B = ~b; ALUop = ALU_ADD;
    lat = 1;
    busy_all = busy;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      busy_all = busy_all & busy;
    end
    res = result;
    if (handshake) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    rst_n = 1'b1;
  endtask

  task automatic test_add;
    int lat; logic [31:0] res; bit b_all;
    run_op(ALU_ADD, 32'h7FFF_FFFF, 32'h1, 1'b1, lat, res, b_all);
    checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency got %0d want 1", lat); end
    checks++; if (res !== 32'h8000_0000) begin errors++; $display("FAIL add_result got %h want 80000000", res); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL add_in_ready_after got %b want 1", in_ready); end
  endtask

  task automatic test_compare;
    int lat; logic [31:0] res; bit b_all;
    run_op(ALU_SLT, 32'hFFFF_FFFF, 32'h1, 1'b1, lat, res, b_all);
    checks++; if (res !== 32'h1) begin errors++; $display("FAIL slt_result got %h want 1", res); end
    run_op(ALU_SLTU, 32'hFFFF_FFFF, 32'h1, 1'b1, lat, res, b_all);
    checks++; if (res !== 32'h0) begin errors++; $display("FAIL sltu_result got %h want 0", res); end
    run_op(ALU_SUB, 32'h0, 32'h1, 1'b1, lat, res, b_all);
    checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sub_result got %h want ffffffff", res); end
  endtask

  task automatic test_shift;
    int lat; logic [31:0] res; bit b_all;
    run_op(ALU_SRA, 32'h8000_0000, 32'd31, 1'b1, lat, res, b_all);
    checks++; if (lat !== 31) begin errors++; $display("FAIL sra_latency got %0d want 31", lat); end
    checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sra_result got %h want ffffffff", res); end
    checks++; if (b_all !== 1'b1) begin errors++; $display("FAIL sra_busy got %b want 1", b_all); end
    run_op(ALU_SRL, 32'h8000_0000, 32'd31, 1'b1, lat, res, b_all);
    checks++; if (res !== 32'h1) begin errors++; $display("FAIL srl_result got %h want 1", res); end
    run_op(ALU_SLL, 32'h1, 32'h0000_0024, 1'b1, lat, res, b_all);
    checks++; if (lat !== 4) begin errors++; $display("FAIL sll4_latency got %0d want 4", lat); end
    checks++; if (res !== 32'd16) begin errors++; $display("FAIL sll4_result got %h want 10", res); end
    run_op(ALU_SLL, 32'hA5A5_0001, 32'h0, 1'b1, lat, res, b_all);
    checks++; if (lat !== 1) begin errors++; $display("FAIL sll0_latency got %0d want 1", lat); end
    checks++; if (res !== 32'hA5A5_0001) begin errors++; $display("FAIL sll0_result got %h want a5a50001", res); end
  endtask

  task automatic test_backpressure;
    int lat; logic [31:0] res; bit b_all; int bad;
    run_op(ALU_XOR, 32'hF0F0_F0F0, 32'hFFFF_0000, 1'b0, lat, res, b_all);
    checks++; if (res !== 32'h0F0F_F0F0) begin errors++; $display("FAIL xor_result got %h want 0f0ff0f0", res); end
    in_valid = 1'b1; A = 32'h1; B = 32'h2;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (result !== 32'h0F0F_F0F0 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold got %0d bad cycles want 0", bad); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_shift;
    int lat; logic [31:0] res; bit b_all; int seen;
    @(negedge clk);
    ALUop = ALU_SLL; A = 32'h1; B = 32'd20; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen = 0;
    for (int i = 1; i < 7; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (seen !== 0) begin errors++; $display("FAIL mid_rst_early_valid got %0d want 0", seen); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_in_ready got %b want 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b want 0", busy); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL mid_rst_result got %h want 0", result); end
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL mid_rst_late_valid got %0d want 0", seen); end
    run_op(ALU_COPY_B, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, lat, res, b_all);
    checks++; if (lat !== 1) begin errors++; $display("FAIL copyb_latency got %0d want 1", lat); end
    checks++; if (res !== 32'h1234_5678) begin errors++; $display("FAIL copyb_result got %h want 12345678", res); end
  endtask

  task automatic test_undefined_and_isolation;
    int lat; logic [31:0] res; bit b_all;
    run_op(ALU_XXX, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, lat, res, b_all);
    checks++; if (lat !== 1) begin errors++; $display("FAIL xxx_latency got %0d want 1", lat); end
    checks++; if (res !== 32'h0) begin errors++; $display("FAIL xxx_result got %h want 0", res); end
    // run_op inverts A and B right after accept; result must use the captured values
    run_op(ALU_SRL, 32'hF000_0000, 32'hFFFF_FFE8, 1'b1, lat, res, b_all);
    checks++; if (lat !== 8) begin errors++; $display("FAIL iso_latency got %0d want 8", lat); end
    checks++; if (res !== 32'h00F0_0000) begin errors++; $display("FAIL iso_result got %h want 00f00000", res); end
  endtask

  initial begin
    test_reset;
    test_add;
    test_compare;
    test_shift;
    test_backpressure;
    test_reset_mid_shift;
    test_undefined_and_isolation;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
